plot_framebuffer: RTL and testbench

Pixel sink and store for the reversi display path. Accepts the per-cycle plot stream (enable, X, Y, 3-bit colour) driven by the drawing engines (board grid, pieces, cursor) into a WIDTH×HEIGHT 3-bit framebuffer. It also serves a raster read-out port for the display side. A built-in clear sequencer fills the whole buffer with a background colour before a redraw.

---
 rtl/plot_framebuffer.sv | 139 +++++++++++++
 tb/tb_plot_framebuffer.sv | 231 +++++++++++++++++++++++
 2 files changed

// File: rtl/plot_framebuffer.sv
// Pixel framebuffer for the reversi display: plot-stream write port, clear sequencer
// and a free-running raster read-out port.
//
// state   | meaning
// --------+---------------------------------------------------------
// S_IDLE  | accepting plot writes; clearReq starts a clear
// S_CLEAR | writing CLEAR_COLOUR to every address, plots ignored
// S_DONE  | one-cycle clearDone pulse, then back to S_IDLE
module plot_framebuffer #(
    parameter int         WIDTH        = 160,
    parameter int         HEIGHT       = 120,
    parameter logic [2:0] CLEAR_COLOUR = 3'b000
) (
    input  logic       clk,
    input  logic       resetn,
    input  logic       plotEn,
    input  logic [7:0] plotX,
    input  logic [7:0] plotY,
    input  logic [2:0] plotColour,
    output logic       plotReady,
    input  logic       clearReq,
    output logic       clearBusy,
    output logic       clearDone,
    output logic [7:0] dropCount,
    input  logic       scanEn,
    output logic [7:0] scanX,
    output logic [7:0] scanY,
    output logic [2:0] scanColour,
    output logic       scanValid,
    output logic       scanFrameStart
);
    localparam int              DEPTH     = WIDTH * HEIGHT;
    localparam int              AW        = $clog2(DEPTH);
    localparam logic [8:0]      W9        = 9'(WIDTH);
    localparam logic [8:0]      H9        = 9'(HEIGHT);
    localparam logic [7:0]      X_LAST    = 8'(WIDTH - 1);
    localparam logic [7:0]      Y_LAST    = 8'(HEIGHT - 1);
    localparam logic [AW-1:0]   ADDR_LAST = AW'(DEPTH - 1);

    typedef enum logic [1:0] {S_IDLE, S_CLEAR, S_DONE} state_t;

    state_t          state, state_next;
    logic [AW-1:0]   clear_addr;
    logic [2:0]      mem [DEPTH];
    logic            in_range;
    logic [AW-1:0]   plot_addr;
    logic [AW-1:0]   rd_addr;
    logic            wr_en;
    logic [AW-1:0]   wr_addr;
    logic [2:0]      wr_data;
    logic [7:0]      rd_x;
    logic [7:0]      rd_y;

    // Range check on the full 8-bit coordinates so nothing aliases into the buffer.
    assign in_range  = ({1'b0, plotX} < W9) && ({1'b0, plotY} < H9);
    assign plot_addr = AW'(plotY) * AW'(WIDTH) + AW'(plotX);
    assign rd_addr   = AW'(rd_y) * AW'(WIDTH) + AW'(rd_x);

    always_ff @(posedge clk) begin
        if (!resetn) begin
            state      <= S_IDLE;
            clear_addr <= '0;
            dropCount  <= '0;
        end else begin
            state <= state_next;
            if (state == S_IDLE) begin
                clear_addr <= '0;
                if (plotEn && !in_range && dropCount != 8'hFF)
                    dropCount <= dropCount + 8'd1;
            end else if (state == S_CLEAR) begin
                clear_addr <= clear_addr + AW'(1);
            end
        end
    end

    always_comb begin
        state_next = state;
        plotReady  = 1'b0;
        clearBusy  = 1'b0;
        clearDone  = 1'b0;
        wr_en      = 1'b0;
        wr_addr    = plot_addr;
        wr_data    = plotColour;
        case (state)
            S_IDLE: begin
                plotReady = 1'b1;
                wr_en     = plotEn && in_range;
                if (clearReq)
                    state_next = S_CLEAR;
            end
            S_CLEAR: begin
                clearBusy = 1'b1;
                wr_en     = 1'b1;
                wr_addr   = clear_addr;
                wr_data   = CLEAR_COLOUR;
                if (clear_addr == ADDR_LAST)
                    state_next = S_DONE;
            end
            S_DONE: begin
                clearDone  = 1'b1;
                state_next = S_IDLE;
            end
            default: state_next = S_IDLE;
        endcase
    end

    // Writes are suppressed in a reset cycle so an aborted clear stops exactly where it was.
    always_ff @(posedge clk) begin
        if (wr_en && resetn)
            mem[wr_addr] <= wr_data;
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            rd_x       <= '0;
            rd_y       <= '0;
            scanX      <= '0;
            scanY      <= '0;
            scanColour <= '0;
            scanValid  <= 1'b0;
        end else begin
            scanValid <= scanEn;
            if (scanEn) begin
                scanX      <= rd_x;
                scanY      <= rd_y;
                scanColour <= mem[rd_addr];
                if (rd_x == X_LAST) begin
                    rd_x <= '0;
                    rd_y <= (rd_y == Y_LAST) ? 8'd0 : rd_y + 8'd1;
                end else begin
                    rd_x <= rd_x + 8'd1;
                end
            end
        end
    end

    assign scanFrameStart = scanValid && (scanX == 8'd0) && (scanY == 8'd0);

endmodule

// File: tb/tb_plot_framebuffer.sv
// Scoreboard bench for plot_framebuffer: scan reads push expected pixels, a negedge
// monitor pops and compares whenever scanValid is presented.
module tb_plot_framebuffer;
    logic       clk = 1'b0;
    logic       resetn;
    logic       plotEn;
    logic [7:0] plotX;
    logic [7:0] plotY;
    logic [2:0] plotColour;
    logic       plotReady;
    logic       clearReq;
    logic       clearBusy;
    logic       clearDone;
    logic [7:0] dropCount;
    logic       scanEn;
    logic [7:0] scanX;
    logic [7:0] scanY;
    logic [2:0] scanColour;
    logic       scanValid;
    logic       scanFrameStart;

    plot_framebuffer dut (
        .clk(clk), .resetn(resetn),
        .plotEn(plotEn), .plotX(plotX), .plotY(plotY), .plotColour(plotColour),
        .plotReady(plotReady), .clearReq(clearReq), .clearBusy(clearBusy),
        .clearDone(clearDone), .dropCount(dropCount), .scanEn(scanEn),
        .scanX(scanX), .scanY(scanY), .scanColour(scanColour),
        .scanValid(scanValid), .scanFrameStart(scanFrameStart)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [7:0] x;
        logic [7:0] y;
        logic [2:0] c;
        bit         chk;
    } exp_t;

    exp_t       q[$];
    exp_t       mon_e;
    logic       mon_fs;
    int         checks = 0;
    int         errors = 0;
    int         fs_seen = 0;
    logic [7:0] mx = 8'd0;
    logic [7:0] my = 8'd0;

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic plot(input logic [7:0] x, input logic [7:0] y, input logic [2:0] c);
        plotX = x; plotY = y; plotColour = c; plotEn = 1'b1;
        tick();
        plotEn = 1'b0;
    endtask

    task automatic scan(input bit chk, input logic [2:0] c);
        q.push_back('{mx, my, c, chk});
        scanEn = 1'b1;
        tick();
        scanEn = 1'b0;
        if (mx == 8'd159) begin
            mx = 8'd0;
            my = (my == 8'd119) ? 8'd0 : my + 8'd1;
        end else begin
            mx = mx + 8'd1;
        end
    endtask

    task automatic do_reset();
        resetn = 1'b0;
        tick();
        resetn = 1'b1;
        mx = 8'd0;
        my = 8'd0;
    endtask

    always @(negedge clk) begin
        if (scanValid) begin
            checks++;
            if (q.size() == 0) begin
                errors++;
                $display("FAIL scan_unexpected: got x=%0d y=%0d, expected no output", scanX, scanY);
            end else begin
                mon_e  = q.pop_front();
                mon_fs = (mon_e.x == 8'd0) && (mon_e.y == 8'd0);
                if (scanX !== mon_e.x || scanY !== mon_e.y || scanFrameStart !== mon_fs ||
                    (mon_e.chk && scanColour !== mon_e.c)) begin
                    errors++;
                    $display("FAIL scan_pixel: got x=%0d y=%0d c=%0d fs=%0d expected x=%0d y=%0d c=%0d fs=%0d",
                             scanX, scanY, scanColour, scanFrameStart,
                             mon_e.x, mon_e.y, mon_e.c, mon_fs);
                end
            end
            if (scanFrameStart) fs_seen++;
        end
    end

    initial begin
        int fs0;
        int busy;
        bit done;
        int late_done;

        resetn = 1'b0; plotEn = 1'b0; plotX = '0; plotY = '0; plotColour = '0;
        clearReq = 1'b0; scanEn = 1'b0;
        tick();
        tick();
        resetn = 1'b1;
        check("rst_plotReady", plotReady, 1);
        check("rst_clearBusy", clearBusy, 0);
        check("rst_clearDone", clearDone, 0);
        check("rst_scanValid", scanValid, 0);
        check("rst_scanFrameStart", scanFrameStart, 0);
        check("rst_scanX", scanX, 0);
        check("rst_scanY", scanY, 0);
        check("rst_scanColour", scanColour, 0);
        check("rst_dropCount", dropCount, 0);

        // Single plot then four rows of scan.
        plot(8'd5, 8'd3, 3'b101);
        fs0 = fs_seen;
        for (int i = 0; i < 640; i++) scan(mx == 8'd5 && my == 8'd3, 3'b101);
        tick();
        tick();
        check("frame_start_4rows", fs_seen - fs0, 1);

        // Full clear with a plot attempt in the middle.
        do_reset();
        clearReq = 1'b1;
        tick();
        clearReq = 1'b0;
        check("clear_busy_start", clearBusy, 1);
        check("clear_plotReady", plotReady, 0);
        busy = 0;
        done = 1'b0;
        for (int n = 0; n < 20000 && !done; n++) begin
            if (clearDone) begin
                done = 1'b1;
            end else begin
                if (clearBusy) busy++;
                plotX = 8'd1; plotY = 8'd1; plotColour = 3'b111;
                plotEn = (busy == 50);
                tick();
                plotEn = 1'b0;
            end
        end
        check("clear_done_seen", done, 1);
        check("clear_busy_cycles", busy, 19200);
        check("done_clearBusy", clearBusy, 0);
        check("done_plotReady", plotReady, 0);
        tick();
        check("after_done_clearDone", clearDone, 0);
        check("after_done_plotReady", plotReady, 1);
        check("clear_drop_unchanged", dropCount, 0);

        // Full frame plus one: all cleared, wraps at row and frame ends.
        fs0 = fs_seen;
        for (int i = 0; i < 19201; i++) scan(1'b1, 3'b000);
        tick();
        tick();
        check("frame_start_wrap", fs_seen - fs0, 2);

        // Out-of-range plots.
        plot(8'd160, 8'd0, 3'b111);
        plot(8'd0, 8'd120, 3'b111);
        plot(8'd255, 8'd255, 3'b111);
        check("drop_three", dropCount, 3);
        for (int i = 0; i < 300; i++) begin
            if (i % 2 == 1) plot(8'(200 + i % 50), 8'd5, 3'b111);
            else            plot(8'd5, 8'(130 + i % 100), 3'b111);
        end
        check("drop_saturate", dropCount, 255);

        // Same-cycle read and write of (10,10).
        do_reset();
        check("drop_after_reset", dropCount, 0);
        plot(8'd10, 8'd10, 3'b111);
        for (int i = 0; i < 1610; i++) scan(1'b1, 3'b000);
        plotX = 8'd10; plotY = 8'd10; plotColour = 3'b010; plotEn = 1'b1;
        scan(1'b1, 3'b111);
        plotEn = 1'b0;
        tick();
        tick();
        do_reset();
        for (int i = 0; i < 1611; i++)
            scan(1'b1, (mx == 8'd10 && my == 8'd10) ? 3'b010 : 3'b000);
        tick();
        tick();

        // Reset in the middle of a clear.
        do_reset();
        for (int i = 0; i <= 100; i++) plot(8'(i), 8'd0, 3'b111);
        clearReq = 1'b1;
        tick();
        clearReq = 1'b0;
        for (int i = 0; i < 100; i++) tick();
        resetn = 1'b0;
        tick();
        resetn = 1'b1;
        mx = 8'd0;
        my = 8'd0;
        check("abort_clearBusy", clearBusy, 0);
        check("abort_plotReady", plotReady, 1);
        check("abort_clearDone", clearDone, 0);
        late_done = 0;
        for (int i = 0; i < 5; i++) begin
            if (clearDone) late_done++;
            tick();
        end
        check("abort_no_done_later", late_done, 0);
        for (int i = 0; i < 101; i++) scan(1'b1, (mx < 8'd100) ? 3'b000 : 3'b111);
        tick();
        tick();

        check("scoreboard_drained", q.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
